// File: rtl/l2_reqs_sched_pkg.sv
// Shared constants and types for the L2 request-buffer lookup scheduler.
// Op codes, source ids and the sequencer state encoding live here.
package l2_reqs_sched_pkg;

    localparam logic [2:0] L2_REQS_LOOKUP     = 3'b000;
    localparam logic [2:0] L2_REQS_PEEK_FWD   = 3'b001;
    localparam logic [2:0] L2_REQS_PEEK_REQ   = 3'b010;
    localparam logic [2:0] L2_REQS_PEEK_FLUSH = 3'b011;

    typedef logic [1:0] src_id_t;

    localparam src_id_t SRC_FWD   = 2'd0;
    localparam src_id_t SRC_RSP   = 2'd1;
    localparam src_id_t SRC_CPU   = 2'd2;
    localparam src_id_t SRC_FLUSH = 2'd3;

    typedef enum logic [1:0] {IDLE, CAPT, RESP} sched_state_t;

    function automatic logic [2:0] src_op_code(input src_id_t src);
        logic [2:0] op;
        case (src)
            SRC_FWD: op = L2_REQS_PEEK_FWD;
            SRC_RSP: op = L2_REQS_LOOKUP;
            SRC_CPU: op = L2_REQS_PEEK_REQ;
            default: op = L2_REQS_PEEK_FLUSH;
        endcase
        return op;
    endfunction

    function automatic src_id_t onehot_to_src(input logic [3:0] gnt);
        src_id_t src;
        if (gnt[3]) begin
            src = SRC_FLUSH;
        end else if (gnt[2]) begin
            src = SRC_CPU;
        end else if (gnt[1]) begin
            src = SRC_RSP;
        end else begin
            src = SRC_FWD;
        end
        return src;
    endfunction

endpackage

// File: rtl/l2_reqs_sched_prio_arb.sv
// Four-input fixed-priority arbiter (0 highest) with a promote path that lets
// the cpu/flush pair jump the queue; prefer_hi picks flush when both are present.
module l2_reqs_prio_arb (
    input  logic [3:0] req,
    input  logic       promote,
    input  logic       prefer_hi,
    output logic [3:0] gnt
);

    always_comb begin
        gnt = 4'b0000;
        if (promote && (req[2] || req[3])) begin
            if (req[3] && (prefer_hi || !req[2])) begin
                gnt[3] = 1'b1;
            end else begin
                gnt[2] = 1'b1;
            end
        end else if (req[0]) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end else if (req[2]) begin
            gnt[2] = 1'b1;
        end else if (req[3]) begin
            gnt[3] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_reqs_sched.sv
// Lookup-port sequencer: arbitrates four requesters, issues one lookup, captures
// the registered result and hands it back over valid/ready; tracks buffer occupancy.
module l2_reqs_sched
    import l2_reqs_sched_pkg::*;
#(
    parameter int unsigned N_REQS     = 4,
    parameter int unsigned REQS_BITS  = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_valid,
    output logic [3:0]           req_ready,
    output logic [2:0]           reqs_op_code,
    output logic                 lookup_en,
    input  logic [REQS_BITS-1:0] reqs_i,
    input  logic                 reqs_hit,
    input  logic                 set_conflict,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_src,
    output logic [REQS_BITS-1:0] res_reqs_i,
    output logic                 res_hit,
    input  logic                 alloc,
    input  logic                 free,
    output logic [REQS_BITS:0]   occupancy,
    output logic                 full,
    output logic                 err
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned OCC_W = REQS_BITS + 1;
    localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);
    localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(N_REQS);

    sched_state_t          state_q, state_d;
    src_id_t               src_q, src_d;
    logic                  res_valid_q, res_valid_d;
    src_id_t               res_src_q, res_src_d;
    logic [REQS_BITS-1:0]  res_reqs_i_q, res_reqs_i_d;
    logic                  res_hit_q, res_hit_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  pend_q, pend_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  err_q, err_d;
    logic [3:0]            wait_q, wait_d;
    logic                  older3_q, older3_d;

    logic       full_w;
    logic       peek_ok;
    logic [3:0] elig;
    logic [3:0] gnt;
    logic       promote;
    logic       issue;
    logic       res_ack;
    src_id_t    win_src;

    assign full_w  = (occ_q == OCC_FULL);
    assign peek_ok = !full_w && !pend_q;
    assign elig    = {req_valid[3] & peek_ok, req_valid[2] & peek_ok, req_valid[1:0]};
    assign promote = (starve_q == STARVE_TOP);

    // Flush is older only if it was already waiting and cpu either was not, or was younger.
    assign older3_d = req_valid[3] && req_valid[2] && wait_q[3] && (!wait_q[2] || older3_q);

    l2_reqs_prio_arb u_arb (
        .req       (elig),
        .promote   (promote),
        .prefer_hi (older3_d),
        .gnt       (gnt)
    );

    assign win_src = onehot_to_src(gnt);
    assign issue   = (state_q == IDLE) && (|elig);
    assign res_ack = (state_q == RESP) && res_ready;

    // Issue is combinational from IDLE; gating with rst keeps it quiet during reset.
    assign lookup_en    = rst && issue;
    assign reqs_op_code = (rst && issue) ? src_op_code(win_src) : L2_REQS_LOOKUP;
    assign req_ready    = res_ack ? (4'(1) << src_q) : 4'b0000;

    assign res_valid  = res_valid_q;
    assign res_src    = res_src_q;
    assign res_reqs_i = res_reqs_i_q;
    assign res_hit    = res_hit_q;
    assign occupancy  = occ_q;
    assign full       = full_w;
    assign err        = err_q;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        res_valid_d  = res_valid_q;
        res_src_d    = res_src_q;
        res_reqs_i_d = res_reqs_i_q;
        res_hit_d    = res_hit_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    src_d   = win_src;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                res_valid_d  = 1'b1;
                res_src_d    = src_q;
                res_reqs_i_d = reqs_i;
                unique case (src_q)
                    SRC_FWD, SRC_RSP: res_hit_d = reqs_hit;
                    SRC_CPU:          res_hit_d = set_conflict;
                    default:          res_hit_d = 1'b0;
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!req_valid[2] && !req_valid[3]) begin
            starve_d = '0;
        end else if (issue && win_src[1]) begin
            starve_d = '0;
        end else if (issue && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // A cpu result flagged as set conflict never fills, so it releases the reservation.
    always_comb begin
        pend_d = pend_q;
        if (alloc || (res_ack && (src_q == SRC_CPU) && res_hit_q)) begin
            pend_d = 1'b0;
        end
        if (issue && win_src[1]) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        occ_d = occ_q;
        err_d = err_q;
        if (alloc && !free) begin
            if (full_w) begin
                err_d = 1'b1;
            end else begin
                occ_d = occ_q + OCC_W'(1);
            end
        end else if (free && !alloc) begin
            if (occ_q == '0) begin
                err_d = 1'b1;
            end else begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    assign wait_d = req_valid & ~req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            src_q        <= SRC_FWD;
            res_valid_q  <= 1'b0;
            res_src_q    <= SRC_FWD;
            res_reqs_i_q <= '0;
            res_hit_q    <= 1'b0;
            starve_q     <= '0;
            pend_q       <= 1'b0;
            occ_q        <= '0;
            err_q        <= 1'b0;
            wait_q       <= 4'b0000;
            older3_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            res_valid_q  <= res_valid_d;
            res_src_q    <= res_src_d;
            res_reqs_i_q <= res_reqs_i_d;
            res_hit_q    <= res_hit_d;
            starve_q     <= starve_d;
            pend_q       <= pend_d;
            occ_q        <= occ_d;
            err_q        <= err_d;
            wait_q       <= wait_d;
            older3_q     <= older3_d;
        end
    end

`ifndef SYNTHESIS
    hold_valid_a: assert property (@(posedge clk) disable iff (!rst)
        (state_q != IDLE) |-> req_valid[src_q]);
`endif

endmodule

// File: tb/tb_l2_reqs_sched.sv
// Randomized bench for l2_reqs_sched against a timestamp-based reference model.
module tb_l2_reqs_sched;
    import l2_reqs_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [2:0] reqs_op_code;
    logic       lookup_en;
    logic [1:0] reqs_i;
    logic       reqs_hit;
    logic       set_conflict;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_src;
    logic [1:0] res_reqs_i;
    logic       res_hit;
    logic       alloc;
    logic       free;
    logic [2:0] occupancy;
    logic       full;
    logic       err;

    always #5 clk = ~clk;

    l2_reqs_sched #(
        .N_REQS     (4),
        .REQS_BITS  (2),
        .STARVE_MAX (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .reqs_op_code (reqs_op_code),
        .lookup_en    (lookup_en),
        .reqs_i       (reqs_i),
        .reqs_hit     (reqs_hit),
        .set_conflict (set_conflict),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_src      (res_src),
        .res_reqs_i   (res_reqs_i),
        .res_hit      (res_hit),
        .alloc        (alloc),
        .free         (free),
        .occupancy    (occupancy),
        .full         (full),
        .err          (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 capture, 2 respond.
    int m_st, m_src, m_cnt, m_occ, m_res_src, m_res_i, cyc;
    bit m_pend, m_err, m_res_valid, m_res_hit;
    int arrive [4];
    bit waiting[4];

    int p_req, p_rerq, p_rdy, p_alloc, p_free, amode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic logic [2:0] exp_op(input int s);
        case (s)
            0:       return L2_REQS_PEEK_FWD;
            1:       return L2_REQS_LOOKUP;
            2:       return L2_REQS_PEEK_REQ;
            default: return L2_REQS_PEEK_FLUSH;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_src = 0; m_cnt = 0; m_occ = 0; m_pend = 0; m_err = 0;
        m_res_valid = 0; m_res_src = 0; m_res_i = 0; m_res_hit = 0;
        for (int k = 0; k < 4; k++) begin
            waiting[k] = 0;
            arrive[k]  = 0;
        end
    endtask

    task automatic drive_inputs(input logic [3:0] rr);
        for (int k = 0; k < 4; k++) begin
            if (rr[k]) req_valid[k] = pct(p_rerq);
            else if (!req_valid[k]) req_valid[k] = pct(p_req);
        end
        res_ready    = pct(p_rdy);
        reqs_i       = 2'($urandom_range(0, 3));
        reqs_hit     = 1'($urandom_range(0, 1));
        set_conflict = 1'($urandom_range(0, 1));
        case (amode)
            0: begin
                alloc = (m_occ < 4) && pct(p_alloc);
                free  = (m_occ > 0) && pct(p_free);
            end
            1: begin
                alloc = (m_occ < 4);
                free  = 1'b0;
            end
            default: begin
                alloc = 1'b0;
                free  = 1'b1;
            end
        endcase
    endtask

    task automatic step();
        int win;
        bit e[4];
        bit ok;
        logic [3:0] rr;
        for (int k = 0; k < 4; k++) begin
            if (!req_valid[k]) waiting[k] = 0;
            else if (!waiting[k]) begin
                waiting[k] = 1;
                arrive[k]  = cyc;
            end
        end
        ok   = (m_occ != 4) && !m_pend;
        e[0] = req_valid[0];
        e[1] = req_valid[1];
        e[2] = req_valid[2] && ok;
        e[3] = req_valid[3] && ok;
        win  = -1;
        if (m_st == 0) begin
            if (m_cnt == 8 && (e[2] || e[3])) begin
                if (e[2] && e[3]) win = (arrive[3] < arrive[2]) ? 3 : 2;
                else win = e[2] ? 2 : 3;
            end else begin
                for (int k = 0; k < 4; k++) if (e[k] && win < 0) win = k;
            end
        end
        rr = (m_st == 2 && res_ready) ? (4'b0001 << m_src) : 4'b0000;

        chk("lookup_en", 32'(lookup_en), 32'(win >= 0));
        chk("op_code", 32'(reqs_op_code), 32'((win >= 0) ? exp_op(win) : L2_REQS_LOOKUP));
        chk("req_ready", 32'(req_ready), 32'(rr));
        chk("res_valid", 32'(res_valid), 32'(m_res_valid));
        if (m_res_valid) begin
            chk("res_src", 32'(res_src), 32'(m_res_src));
            chk("res_reqs_i", 32'(res_reqs_i), 32'(m_res_i));
            chk("res_hit", 32'(res_hit), 32'(m_res_hit));
        end
        chk("occupancy", 32'(occupancy), 32'(m_occ));
        chk("full", 32'(full), 32'(m_occ == 4));
        chk("err", 32'(err), 32'(m_err));

        @(posedge clk);
        #1;
        if (alloc) m_pend = 0;
        if (m_st == 2 && res_ready && m_src == 2 && m_res_hit) m_pend = 0;
        if (win >= 2) m_pend = 1;
        if (!req_valid[2] && !req_valid[3]) m_cnt = 0;
        else if (win >= 2) m_cnt = 0;
        else if (win >= 0 && m_cnt < 8) m_cnt++;
        case (m_st)
            0: if (win >= 0) begin
                m_src = win;
                m_st  = 1;
            end
            1: begin
                m_res_valid = 1;
                m_res_src   = m_src;
                m_res_i     = int'(reqs_i);
                m_res_hit   = (m_src < 2) ? reqs_hit : ((m_src == 2) ? set_conflict : 1'b0);
                m_st        = 2;
            end
            default: if (res_ready) begin
                m_res_valid = 0;
                m_st        = 0;
            end
        endcase
        if (alloc && !free) begin
            if (m_occ == 4) m_err = 1;
            else m_occ++;
        end else if (free && !alloc) begin
            if (m_occ == 0) m_err = 1;
            else m_occ--;
        end
        for (int k = 0; k < 4; k++) if (rr[k]) waiting[k] = 0;
        cyc++;
        drive_inputs(rr);
        #1;
    endtask

    task automatic set_knobs(input int rq, input int rrq, input int rd, input int pa,
                             input int pf, input int am);
        p_req = rq; p_rerq = rrq; p_rdy = rd; p_alloc = pa; p_free = pf; amode = am;
    endtask

    initial begin
        bit found;
        cyc = 0;
        model_reset();
        rst = 1'b0; req_valid = 4'b0001; res_ready = 1'b0; reqs_i = '0; reqs_hit = 1'b0;
        set_conflict = 1'b0; alloc = 1'b0; free = 1'b0;
        #12;
        chk("reset_out", 32'({lookup_en, reqs_op_code, req_ready, res_valid, res_src,
                              res_reqs_i, res_hit, occupancy, full, err}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;

        // Lone fwd request: exact issue/capture/respond timing.
        set_knobs(0, 0, 100, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();
        // All requesters saturated: starvation promotion of cpu then flush.
        set_knobs(100, 100, 100, 50, 50, 0);
        for (int i = 0; i < 300; i++) step();
        set_knobs(40, 50, 60, 30, 30, 0);
        for (int i = 0; i < 1500; i++) step();
        // Buffer full: only fwd/rsp may issue; then drain.
        set_knobs(100, 100, 80, 0, 0, 1);
        for (int i = 0; i < 100; i++) step();
        set_knobs(100, 100, 80, 0, 100, 0);
        for (int i = 0; i < 30; i++) step();

        // Asynchronous reset while a lookup is being captured.
        set_knobs(100, 100, 100, 30, 30, 0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_st == 1) found = 1;
            else step();
        end
        chk("capt_reached", 32'(found), 32'd1);
        if (found) begin
            rst = 1'b0;
            #1;
            chk("rst_mid", 32'({lookup_en, reqs_op_code, req_ready, res_valid, res_src,
                                res_reqs_i, res_hit, occupancy, full, err}), 32'd0);
            @(posedge clk);
            #2;
            rst = 1'b1;
            model_reset();
            #1;
        end
        for (int i = 0; i < 40; i++) step();

        // Frees past empty set the sticky error.
        set_knobs(40, 50, 60, 0, 0, 2);
        for (int i = 0; i < 8; i++) step();
        set_knobs(40, 50, 60, 40, 40, 0);
        for (int i = 0; i < 100; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
